// File: rtl/force_eval_fifo_pkg.sv
// Shared constants and helpers for the force_eval FIFO: occupancy width and read-mode selectors.
package force_eval_fifo_pkg;

    localparam int SHOWAHEAD_OFF = 0;
    localparam int SHOWAHEAD_ON  = 1;

    // One extra bit so occupancy can reach DEPTH without wrapping.
    function automatic int fifo_cw(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/force_eval_fifo_ram.sv
// Simple dual-port storage with a registered, enable-gated read port (one-cycle latency).
module force_eval_fifo_ram #(
    parameter int DATA_WIDTH = 113,
    parameter int DEPTH      = 512,
    localparam int AW        = $clog2(DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic                  we_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic                  re_i,
    input  logic [AW-1:0]         raddr_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Only the read register is reset; the array contents never need clearing.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rdata_q <= '0;
        end else if (clr_i) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/force_eval_fifo_param.sv
// Single-clock parameterised FIFO with registered status flags, sticky error flags and
// optional show-ahead read mode built on top of a registered-read RAM.
module force_eval_fifo_param
    import force_eval_fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 113,
    parameter int DEPTH      = 512,
    parameter int AF_LEVEL   = 480,
    parameter int AE_LEVEL   = 32,
    parameter int SHOWAHEAD  = 0,
    localparam int CW        = fifo_cw(DEPTH)
) (
    input  logic                  clock,
    input  logic                  aclr,
    input  logic                  sclr,
    input  logic [DATA_WIDTH-1:0] data,
    input  logic                  wrreq,
    input  logic                  rdreq,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] q,
    output logic [CW-1:0]         usedw,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int AW = CW - 1;
    localparam logic [CW-1:0] DEPTH_W = CW'(DEPTH);
    localparam logic [CW-1:0] AF_W    = CW'(AF_LEVEL);
    localparam logic [CW-1:0] AE_W    = CW'(AE_LEVEL);

    if ((DEPTH < 4) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("force_eval_fifo_param: DEPTH must be a power of two and at least 4");
    end
    if ((AF_LEVEL < 1) || (AF_LEVEL > DEPTH)) begin : g_bad_af
        $error("force_eval_fifo_param: AF_LEVEL must lie in 1..DEPTH");
    end
    if ((AE_LEVEL < 1) || (AE_LEVEL > DEPTH)) begin : g_bad_ae
        $error("force_eval_fifo_param: AE_LEVEL must lie in 1..DEPTH");
    end
    if ((SHOWAHEAD != SHOWAHEAD_OFF) && (SHOWAHEAD != SHOWAHEAD_ON)) begin : g_bad_mode
        $error("force_eval_fifo_param: SHOWAHEAD must be 0 or 1");
    end

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] usedw_q, usedw_d;
    logic          full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
    logic          empty_d, ovf_d, unf_d;
    logic          wr_acc, rd_acc, fetch;

    assign wr_acc = wrreq & ~full_q;
    assign rd_acc = rdreq & ~empty_q;

    assign usedw_d = (wr_acc && !rd_acc) ? usedw_q + CW'(1) :
                     (rd_acc && !wr_acc) ? usedw_q - CW'(1) : usedw_q;

    assign wr_ptr_d = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
    assign rd_ptr_d = fetch  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    assign ovf_d = (wrreq & full_q)  | (ovf_q & ~clr_err);
    assign unf_d = (rdreq & empty_q) | (unf_q & ~clr_err);

    if (SHOWAHEAD == SHOWAHEAD_ON) begin : g_showahead
        // Words already in RAM but not yet on q; a word written this edge is not counted,
        // which is what gives the one-cycle empty latency after a write into an empty FIFO.
        logic [CW-1:0] unfetched;
        assign unfetched = usedw_q - {{(CW-1){1'b0}}, ~empty_q};
        assign fetch     = (unfetched != '0) && (empty_q || rd_acc);
        assign empty_d   = ~(fetch || (~empty_q && ~rd_acc));
    end else begin : g_normal
        assign fetch   = rd_acc;
        assign empty_d = (usedw_d == '0);
    end

    always_ff @(posedge clock or posedge aclr) begin
        if (aclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else if (sclr) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            usedw_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            usedw_q  <= usedw_d;
            full_q   <= (usedw_d == DEPTH_W);
            empty_q  <= empty_d;
            af_q     <= (usedw_d >= AF_W);
            ae_q     <= (usedw_d < AE_W);
            ovf_q    <= ovf_d;
            unf_q    <= unf_d;
        end
    end

    force_eval_fifo_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (DEPTH)
    ) u_ram (
        .clk_i   (clock),
        .rst_i   (aclr),
        .clr_i   (sclr),
        .we_i    (wr_acc & ~sclr),
        .waddr_i (wr_ptr_q),
        .wdata_i (data),
        .re_i    (fetch & ~sclr),
        .raddr_i (rd_ptr_q),
        .rdata_o (q)
    );

    assign usedw        = usedw_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign overflow     = ovf_q;
    assign underflow    = unf_q;

endmodule

// File: tb/tb_force_eval_fifo_param.sv
// Bench for force_eval_fifo_param: normal and show-ahead instances share one stimulus stream
// and are checked every cycle against a queue-based model plus literal spot checks.
module tb_force_eval_fifo_param;

    localparam int DW    = 8;
    localparam int DEPTH = 16;
    localparam int AF    = 12;
    localparam int AE    = 4;

    logic          clock = 1'b0;
    logic          aclr = 1'b0, sclr = 1'b0, wrreq = 1'b0, rdreq = 1'b0, clr_err = 1'b0;
    logic [DW-1:0] data = '0;

    logic [DW-1:0] d0_q, d1_q;
    logic [4:0]    d0_usedw, d1_usedw;
    logic          d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf;
    logic          d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf;

    always #5 clock = ~clock;

    force_eval_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(0)) u_norm (
        .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .clr_err(clr_err), .q(d0_q), .usedw(d0_usedw), .full(d0_full), .empty(d0_empty),
        .almost_full(d0_af), .almost_empty(d0_ae), .overflow(d0_ovf), .underflow(d0_unf));

    force_eval_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(AF), .AE_LEVEL(AE), .SHOWAHEAD(1)) u_show (
        .clock(clock), .aclr(aclr), .sclr(sclr), .data(data), .wrreq(wrreq), .rdreq(rdreq),
        .clr_err(clr_err), .q(d1_q), .usedw(d1_usedw), .full(d1_full), .empty(d1_empty),
        .almost_full(d1_af), .almost_empty(d1_ae), .overflow(d1_ovf), .underflow(d1_unf));

    // Model: contents as queues; show-ahead presents the head only once it has sat in the
    // FIFO across at least one edge.
    logic [DW-1:0] m0[$];
    logic [DW-1:0] m1[$];
    logic [DW-1:0] mq0 = '0, mq1 = '0;
    bit            shown1 = 0, m_ovf0 = 0, m_unf0 = 0, m_ovf1 = 0, m_unf1 = 0;
    int            p0, p1;
    bit            pop1;
    int            n_cmp = 0, n_err = 0;

    function automatic void model_reset();
        m0.delete();
        m1.delete();
        mq0 = '0;
        mq1 = '0;
        shown1 = 0;
        m_ovf0 = 0; m_unf0 = 0; m_ovf1 = 0; m_unf1 = 0;
    endfunction

    always @(posedge clock or posedge aclr) begin
        if (aclr || sclr) begin
            model_reset();
        end else begin
            p0 = m0.size();
            m_ovf0 = (wrreq && p0 == DEPTH) || (m_ovf0 && !clr_err);
            m_unf0 = (rdreq && p0 == 0)     || (m_unf0 && !clr_err);
            if (rdreq && p0 != 0) mq0 = m0.pop_front();
            if (wrreq && p0 != DEPTH) m0.push_back(data);

            p1 = m1.size();
            pop1 = rdreq && shown1;
            m_ovf1 = (wrreq && p1 == DEPTH) || (m_ovf1 && !clr_err);
            m_unf1 = (rdreq && !shown1)     || (m_unf1 && !clr_err);
            if (pop1) void'(m1.pop_front());
            if (wrreq && p1 != DEPTH) m1.push_back(data);
            shown1 = (p1 - (pop1 ? 1 : 0)) > 0;
            if (shown1) mq1 = m1[0];
        end
    end

    logic [18:0] exp0, act0, exp1, act1;
    always @(negedge clock) begin
        exp0 = {mq0, 5'(m0.size()), m0.size() == DEPTH, m0.size() == 0, m0.size() >= AF,
                m0.size() < AE, m_ovf0, m_unf0};
        act0 = {d0_q, d0_usedw, d0_full, d0_empty, d0_af, d0_ae, d0_ovf, d0_unf};
        exp1 = {mq1, 5'(m1.size()), m1.size() == DEPTH, !shown1, m1.size() >= AF,
                m1.size() < AE, m_ovf1, m_unf1};
        act1 = {d1_q, d1_usedw, d1_full, d1_empty, d1_af, d1_ae, d1_ovf, d1_unf};
        n_cmp += 2;
        if (act0 !== exp0) begin
            n_err++;
            $display("FAIL model_normal t=%0t actual{q,usedw,full,empty,af,ae,ovf,unf}=%h required=%h", $time, act0, exp0);
        end
        if (act1 !== exp1) begin
            n_err++;
            $display("FAIL model_showahead t=%0t actual{q,usedw,full,empty,af,ae,ovf,unf}=%h required=%h", $time, act1, exp1);
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s t=%0t actual=%0h required=%0h", nm, $time, act, req);
        end
    endtask

    task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
        wrreq = w;
        rdreq = r;
        data  = d;
        @(posedge clock);
        @(negedge clock);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        #1 aclr = 1'b1;
        step(0, 0, 8'h00);
        step(1, 0, 8'hEE);
        chk("rst_q", d0_q, 0);
        chk("rst_usedw", d0_usedw, 0);
        chk("rst_empty", d0_empty, 1);
        chk("rst_ae", d0_ae, 1);
        chk("rst_full", d0_full, 0);
        chk("rst_af", d0_af, 0);
        chk("rst_flags", {d0_ovf, d0_unf}, 0);
        chk("rst_sa_empty", d1_empty, 1);
        aclr = 1'b0;

        // fill to full, almost_full threshold, overflow
        for (int i = 1; i <= 16; i++) begin
            step(1, 0, 8'(i));
            if (i == 1)  chk("first_write_usedw", d0_usedw, 1);
            if (i == 11) chk("af_below", d0_af, 0);
            if (i == 12) chk("af_at12", {d0_af, d0_usedw}, {1'b1, 5'd12});
        end
        chk("full_usedw", d0_usedw, 16);
        chk("full_flag", {d0_full, d0_af, d1_full}, 3'b111);
        step(1, 0, 8'h11);
        chk("overflow_set", {d0_ovf, d1_ovf}, 2'b11);
        chk("overflow_usedw", d0_usedw, 16);
        for (int i = 1; i <= 16; i++) begin
            step(0, 1, 8'h00);
            chk("read_order", d0_q, i);
            if (i < 16) chk("sa_read_order", d1_q, i + 1);
        end
        chk("drained", {d0_empty, d0_usedw, d1_empty}, {1'b1, 5'd0, 1'b1});
        clr_err = 1'b1;
        step(0, 0, 8'h00);
        clr_err = 1'b0;
        chk("overflow_clr", d0_ovf, 0);

        // steady-state streaming across the pointer wrap
        for (int i = 0; i < 5; i++) step(1, 0, 8'(8'h20 + i));
        chk("stream_start", d0_usedw, 5);
        for (int i = 0; i < 20; i++) begin
            step(1, 1, 8'(8'h25 + i));
            chk("stream_q", d0_q, 8'h20 + i);
            chk("stream_sa_q", d1_q, 8'h21 + i);
            chk("stream_usedw", d0_usedw, 5);
        end
        chk("stream_err", {d0_ovf, d0_unf, d1_ovf, d1_unf}, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 8'h00);
            chk("stream_drain_q", d0_q, 8'h34 + i);
        end
        chk("stream_empty", d0_empty, 1);

        // underflow stickiness
        step(0, 1, 8'h00);
        chk("underflow_set", {d0_unf, d1_unf}, 2'b11);
        chk("underflow_q_hold", d0_q, 8'h38);
        clr_err = 1'b1;
        step(0, 1, 8'h00);
        chk("underflow_wins", d0_unf, 1);
        step(0, 0, 8'h00);
        clr_err = 1'b0;
        chk("underflow_clr", {d0_unf, d1_unf}, 0);

        // show-ahead first-word latency
        step(1, 0, 8'hA5);
        chk("sa_lat_empty", {d1_empty, d1_usedw}, {1'b1, 5'd1});
        chk("norm_wr_empty", d0_empty, 0);
        step(0, 0, 8'h00);
        chk("sa_q", d1_q, 8'hA5);
        chk("sa_empty", d1_empty, 0);
        step(0, 1, 8'h00);
        chk("sa_pop", {d1_empty, d1_usedw}, {1'b1, 5'd0});
        chk("norm_pop_q", d0_q, 8'hA5);

        // mixed traffic, model-checked
        for (int i = 0; i < 40; i++) step((i % 3) != 2, (i % 2) == 0, 8'(8'h40 + i));
        for (int i = 0; i < 18; i++) step(0, 1, 8'h00);
        sclr = 1'b1;
        step(0, 0, 8'h00);
        sclr = 1'b0;
        chk("sclr_clean", d0_usedw, 0);

        // sclr beats wrreq, then asynchronous clear mid-cycle
        for (int i = 0; i < 9; i++) step(1, 0, 8'(8'h60 + i));
        chk("pre_sclr_usedw", d0_usedw, 9);
        sclr = 1'b1;
        step(1, 0, 8'hFF);
        sclr = 1'b0;
        chk("sclr_state", {d0_usedw, d0_empty, d0_ae, d0_q}, {5'd0, 1'b1, 1'b1, 8'h00});
        for (int i = 0; i < 3; i++) step(1, 0, 8'(8'h70 + i));
        step(0, 1, 8'h00);
        chk("post_sclr_q", d0_q, 8'h70);
        #2 aclr = 1'b1;
        #1;
        chk("aclr_async", {d0_q, d0_usedw, d0_empty, d0_ae, d0_full, d0_af}, {8'h00, 5'd0, 4'b1100});
        chk("aclr_async_sa", {d1_usedw, d1_empty}, {5'd0, 1'b1});
        step(1, 1, 8'h80);
        chk("aclr_hold", d0_usedw, 0);
        aclr = 1'b0;
        step(1, 0, 8'h81);
        chk("after_aclr_usedw", d0_usedw, 1);
        step(0, 1, 8'h00);
        chk("after_aclr_q", d0_q, 8'h81);
        step(0, 0, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/force_eval_fifo_param.md
FORCE_EVAL_FIFO_PARAM -- requirements
Module: force_eval_fifo_param

Interface
REQ-001 Parameter DATA_WIDTH, default 113, word width in bits.
REQ-002 Parameter DEPTH, default 512, number of words; SHALL be a power of 2 and at least 4.
REQ-003 Parameter AF_LEVEL, default 480, almost_full threshold; legal range 1..DEPTH.
REQ-004 Parameter AE_LEVEL, default 32, almost_empty threshold; legal range 1..DEPTH.
REQ-005 Parameter SHOWAHEAD, default 0; 0 = normal read, 1 = show-ahead read.
REQ-006 Ports SHALL be (local CW = $clog2(DEPTH)+1):
- clock  in  1  single clock, rising edge.
- aclr  in  1  asynchronous, active-high reset.
- sclr  in  1  synchronous clear.
- data  in  DATA_WIDTH  write word.
- wrreq  in  1  write request.
- rdreq  in  1  read request.
- clr_err  in  1  clears sticky error flags.
- q  out  DATA_WIDTH  read word.
- usedw  out  CW  occupancy; reaches DEPTH without wrapping.
- full, empty, almost_full, almost_empty  out  1 each  status flags.
- overflow, underflow  out  1 each  sticky error flags.

Function
REQ-007 A write SHALL be accepted iff wrreq=1 and full=0; a read SHALL be accepted iff rdreq=1 and empty=0.
REQ-008 Simultaneous accepted read and write SHALL leave usedw unchanged.
REQ-009 When full=1 with wrreq=rdreq=1, the read SHALL be accepted and the write rejected.
REQ-010 Read and write pointers SHALL wrap modulo DEPTH.
REQ-011 usedw, full, empty, almost_full and almost_empty SHALL be registered and updated on the same edge as the accepted operation.
REQ-012 Flag definitions:
- full = (usedw == DEPTH)
- almost_full = (usedw >= AF_LEVEL)
- almost_empty = (usedw < AE_LEVEL)
REQ-013 SHOWAHEAD=0:
- empty = (usedw == 0).
- q SHALL update one cycle after an accepted read and hold its value otherwise.
REQ-014 SHOWAHEAD=1:
- empty=0 means the head word is valid on q.
- After a write into an empty FIFO, q SHALL show that word and empty SHALL deassert exactly one cycle later.
- On an accepted read, the next word (if any) SHALL appear on q on the following edge with no empty bubble.
- usedw SHALL count the presented word.
REQ-015 Error flags:
- overflow SHALL set on wrreq=1 while full=1.
- underflow SHALL set on rdreq=1 while empty=1.
- Both SHALL be sticky until clr_err=1.
- A set event SHALL win over clr_err in the same cycle.
REQ-016 Rejected operations SHALL NOT alter storage, pointers or usedw.
REQ-017 sclr=1 SHALL, at the next edge, restore all state to its reset values, taking priority over wrreq, rdreq and clr_err in that cycle.
REQ-018 Storage contents SHALL NOT require clearing on sclr or aclr.

Reset
REQ-019 aclr=1 SHALL immediately force all outputs to their reset values, independent of clock:
- q = 0
- usedw = 0
- empty = 1
- almost_empty = 1
- full = 0
- almost_full = 0
- overflow = 0
- underflow = 0
REQ-020 Reset values SHALL hold throughout aclr; the first operation SHALL be accepted on the first rising edge after aclr deasserts.
REQ-021 aclr asserted mid-operation SHALL discard all stored words; no partial write SHALL be visible afterwards.

Structure
REQ-022 Package force_eval_fifo_pkg SHALL hold the CW width function and the SHOWAHEAD mode constants.
REQ-023 Storage SHALL be one sub-module, force_eval_fifo_ram:
- simple dual-port, registered read, one-cycle latency;
- the show-ahead prefetch logic SHALL reside in the parent.
REQ-024 Parameter legality (REQ-002..004) SHALL be checked at elaboration time.

Verification (DATA_WIDTH=8, DEPTH=16, AF_LEVEL=12, AE_LEVEL=4)
REQ-025 Write 0x01..0x10 (16 words):
- usedw=16, full=1, almost_full=1 from the 12th write;
- a 17th write sets overflow and usedw stays 16;
- 16 reads return 0x01..0x10 in order, then empty=1.
REQ-026 From usedw=5, hold wrreq=rdreq=1 for 20 cycles (pointer wrap) -> usedw stays 5, data emerges in order, no error flags.
REQ-027 SHOWAHEAD=1, write 0xA5 into empty FIFO -> one cycle later q=0xA5 and empty=0; rdreq pops it -> empty=1, usedw=0.
REQ-028 rdreq on empty FIFO -> underflow=1, q unchanged; clr_err and rdreq in the same cycle -> underflow stays 1; clr_err alone -> 0.
REQ-029 With usedw=9, assert sclr with wrreq=1 -> usedw=0, empty=1, almost_empty=1; then assert aclr between clock edges -> outputs reset at once.
